sram_word_bridge: RTL

- Upstream stage of the 8-bit async SRAM controller.
- Accepts 32-bit word read/write requests from the RISC-V core's local data bus.
- Splits each request into sequential byte cycles on the controller's go/busy interface.
- Assembles read bytes into a 32-bit word and returns it with a single-cycle ack.

---
 rtl/sram_pkg.sv | 14 +
 rtl/sram_word_cache.sv | 44 ++++
 rtl/sram_word_bridge.sv | 130 +++++++++++++
 3 files changed

// File: rtl/sram_pkg.sv
// Shared types and constants for the SRAM word bridge: FSM encoding, default
// widths and the lane-to-bit-slice helper.
package sram_pkg;
    localparam int ADDR_W_DEF = 17;
    localparam int LANES_DEF  = 4;
    localparam int BYTE_W     = 8;

    typedef enum logic [2:0] {IDLE, NEXT, GO, WRISE, WFALL, DONE} state_t;

    // LSB position of a byte lane inside the 32-bit word.
    function automatic int lane_lsb(input int lane);
        return lane * BYTE_W;
    endfunction
endpackage

// File: rtl/sram_word_cache.sv
// One-entry read cache (valid, tag, data) with byte merge on write hits.
// Instantiated by sram_word_bridge only when SRAM_WORD_BRIDGE_RDCACHE_EN is defined.
module sram_word_cache
    import sram_pkg::*;
#(
    parameter int TAG_W = ADDR_W_DEF - 2,
    parameter int LANES = LANES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [TAG_W-1:0]        lookup_tag,
    output logic                    hit,
    output logic [LANES*BYTE_W-1:0] data,
    input  logic                    fill,
    input  logic [TAG_W-1:0]        fill_tag,
    input  logic [LANES*BYTE_W-1:0] fill_data,
    input  logic                    merge,
    input  logic [LANES-1:0]        merge_be,
    input  logic [LANES*BYTE_W-1:0] merge_data
);
    logic                    valid;
    logic [TAG_W-1:0]        tag_q;
    logic [LANES*BYTE_W-1:0] data_q;

    assign hit  = valid && (tag_q == lookup_tag);
    assign data = data_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid  <= 1'b0;
            tag_q  <= '0;
            data_q <= '0;
        end else if (fill) begin
            valid  <= 1'b1;
            tag_q  <= fill_tag;
            data_q <= fill_data;
        end else if (merge && hit) begin
            // Write to the cached word: keep it coherent, valid stays set.
            for (int i = 0; i < LANES; i++)
                if (merge_be[i])
                    data_q[lane_lsb(i) +: BYTE_W] <= merge_data[lane_lsb(i) +: BYTE_W];
        end
    end
endmodule

// File: rtl/sram_word_bridge.sv
// Splits 32-bit word requests into byte cycles on the 8-bit SRAM controller's
// go/busy interface. Optional read cache: define SRAM_WORD_BRIDGE_RDCACHE_EN.
module sram_word_bridge
    import sram_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int LANES  = LANES_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req,
    output logic                    ready,
    input  logic                    we,
    input  logic [ADDR_W-1:0]       addr,
    input  logic [LANES-1:0]        be,
    input  logic [LANES*BYTE_W-1:0] wdata,
    output logic [LANES*BYTE_W-1:0] rdata,
    output logic                    ack,
    output logic                    mem_go,
    output logic                    mem_wr,
    output logic [ADDR_W-1:0]       mem_adr,
    output logic [BYTE_W-1:0]       mem_dat,
    input  logic [BYTE_W-1:0]       mem_rdt,
    input  logic                    mem_busy
);
    state_t                  state, state_nxt;
    logic                    we_q, hit_q;
    logic [ADDR_W-3:0]       addr_hi;
    logic [LANES-1:0]        be_q, need;
    logic [LANES*BYTE_W-1:0] wdata_q;
    logic [2:0]              cnt;
    logic                    accept, found, hit;
    logic [1:0]              lane_sel;
    logic [LANES*BYTE_W-1:0] cache_data;
    logic                    unused;

    assign unused = &{1'b0, addr[1:0]};
    assign ready  = (state == IDLE) && !mem_busy;
    assign accept = req && ready;

`ifdef SRAM_WORD_BRIDGE_RDCACHE_EN
    sram_word_cache #(.TAG_W(ADDR_W-2), .LANES(LANES)) u_cache (
        .clk        (clk),
        .rst_n      (rst_n),
        .lookup_tag (addr[ADDR_W-1:2]),
        .hit        (hit),
        .data       (cache_data),
        .fill       ((state == DONE) && !we_q),
        .fill_tag   (addr_hi),
        .fill_data  (rdata),
        .merge      (accept && we),
        .merge_be   (be),
        .merge_data (wdata)
    );
`else
    assign hit        = 1'b0;
    assign cache_data = '0;
`endif

    // Lowest lane at or above the counter that still needs a controller cycle;
    // disabled write lanes are skipped without spending a cycle each.
    always_comb begin
        need     = we_q ? be_q : (hit_q ? '0 : '1);
        found    = 1'b0;
        lane_sel = '0;
        for (int i = LANES-1; i >= 0; i--)
            if (need[i] && (i >= int'(cnt))) begin
                found    = 1'b1;
                lane_sel = 2'(i);
            end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (accept) state_nxt = NEXT;
            NEXT:    state_nxt = found ? GO : DONE;
            GO:      state_nxt = WRISE;
            WRISE:   if (mem_busy) state_nxt = WFALL;
            WFALL:   if (!mem_busy) state_nxt = NEXT;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            hit_q   <= 1'b0;
            addr_hi <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            cnt     <= '0;
            rdata   <= '0;
            ack     <= 1'b0;
            mem_go  <= 1'b0;
            mem_wr  <= 1'b0;
            mem_adr <= '0;
            mem_dat <= '0;
        end else begin
            state  <= state_nxt;
            // go/ack flops line up with the GO and DONE states.
            mem_go <= (state == NEXT) && found;
            ack    <= (state == NEXT) && !found;
            if (accept) begin
                we_q    <= we;
                hit_q   <= !we && hit;
                addr_hi <= addr[ADDR_W-1:2];
                be_q    <= be;
                wdata_q <= wdata;
                cnt     <= '0;
                if (!we && hit) rdata <= cache_data;
            end
            if ((state == NEXT) && found) begin
                cnt     <= {1'b0, lane_sel};
                mem_wr  <= we_q;
                mem_adr <= {addr_hi, lane_sel};
                mem_dat <= wdata_q[lane_lsb(int'(lane_sel)) +: BYTE_W];
            end
            if ((state == WFALL) && !mem_busy) begin
                if (!we_q) rdata[lane_lsb(int'(cnt[1:0])) +: BYTE_W] <= mem_rdt;
                cnt <= cnt + 3'd1;
            end
        end
    end

    a_go_spaced: assert property (@(posedge clk) disable iff (!rst_n) mem_go |=> !mem_go);
    a_go_idle:   assert property (@(posedge clk) disable iff (!rst_n) !(mem_go && mem_busy));
endmodule
